// File: rtl/boot_rom_reader_pkg.sv
// Shared types and constants for the boot ROM reader: FSM states, default ROM base
// address, word size and the tagged read-data entry carried through the FIFO.
package boot_rom_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [31:0] DEFAULT_ADDR_OFFSET = 32'h1a00_0000;
   localparam int unsigned WORD_BYTES          = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/boot_rom_reader_fifo.sv
// Synchronous FIFO for the ROM read path. The head entry comes straight from the
// storage flops, so the consumer never sees a combinational path from the push side.
module boot_rom_reader_fifo
   import boot_rom_reader_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type entry_t = fifo_entry_t
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  entry_t                 data_i,
   input  logic                   pop_i,
   output entry_t                 data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             do_push_s;
   logic             do_pop_s;

   // Next-state for storage, pointers and occupancy; a push into a full FIFO is
   // accepted only when the head leaves in the same cycle.
   always_comb begin
      do_pop_s  = pop_i && (count_q != {CNT_W{1'b0}});
      do_push_s = push_i && ((count_q != FULL_COUNT) || do_pop_s);
      mem_d     = mem_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == FULL_COUNT);
   assign empty_o = (count_q == {CNT_W{1'b0}});
   assign count_o = count_q;

endmodule

// File: rtl/boot_rom_reader.sv
// Boot ROM read engine: validates a request, streams sequential ROM words into a FIFO
// and out on valid/ready. Define BOOT_ROM_READER_CHECKSUM_EN for the running checksum.
module boot_rom_reader
   import boot_rom_reader_pkg::*;
#(
   parameter int unsigned ROM_ADDR_WIDTH = 13,
   parameter logic [31:0] AddrOffset     = DEFAULT_ADDR_OFFSET,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter logic [3:0]  ID             = 4'h0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [31:0]             base_i,
   input  logic [ROM_ADDR_WIDTH:0] len_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic                    rom_csn_o,
   output logic                    rom_wen_o,
   output logic                    rom_be_o,
   output logic [31:0]             rom_add_o,
   output logic [31:0]             rom_wdata_o,
   output logic [3:0]              rom_id_o,
   input  logic [31:0]             rom_rdata_i,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic [31:0]             m_data_o,
   output logic [31:0]             m_addr_o,
   output logic [31:0]             checksum_o
);

   localparam int unsigned LEN_W = ROM_ADDR_WIDTH + 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OCC_W = CNT_W + 1;
   localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FIFO_DEPTH);
   localparam logic [32:0]      ROM_WORDS = 33'd1 << ROM_ADDR_WIDTH;
   localparam logic [31:0]      WORD_STEP = 32'(WORD_BYTES);

   state_e            state_q;
   state_e            state_d;
   logic              busy_q;
   logic              busy_d;
   logic              done_q;
   logic              done_d;
   logic              err_q;
   logic              err_d;
   logic              csn_q;
   logic              csn_d;
   logic [31:0]       add_q;
   logic [31:0]       add_d;
   logic [LEN_W-1:0]  remain_q;
   logic [LEN_W-1:0]  remain_d;
   logic              rvalid_q;
   logic              rvalid_d;
   logic [31:0]       rtag_q;
   logic [31:0]       rtag_d;

   logic [31:0]       byte_off_s;
   logic [32:0]       end_word_s;
   logic              req_bad_s;
   logic [OCC_W-1:0]  occ_s;
   logic              can_issue_s;
   logic              pop_s;
   fifo_entry_t       push_entry_s;
   fifo_entry_t       pop_entry_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;

   // Request validation; the end-of-range sum is kept 33 bits wide so it cannot wrap.
   always_comb begin
      byte_off_s = base_i - AddrOffset;
      end_word_s = ({1'b0, byte_off_s} >> 2) + 33'(len_i);
      req_bad_s  = (base_i[1:0] != 2'b00) || (base_i < AddrOffset) || (end_word_s > ROM_WORDS);
   end

   // A new read may issue only if every word already committed (buffered, returning
   // this cycle, or issued this cycle) still leaves a free FIFO slot next cycle.
   always_comb begin
      pop_s       = !fifo_empty_s && m_ready_i;
      occ_s       = {1'b0, fifo_count_s}
                  + {{CNT_W{1'b0}}, rvalid_q}
                  + {{CNT_W{1'b0}}, !csn_q}
                  - {{CNT_W{1'b0}}, pop_s};
      can_issue_s = !fifo_full_s && (occ_s < OCC_LIMIT);
   end

   // Transfer FSM next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      csn_d    = 1'b1;
      add_d    = add_q;
      remain_d = remain_q;
      rvalid_d = !csn_q;
      rtag_d   = add_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start_i && req_bad_s) begin
               err_d = 1'b1;
            end else if (start_i && (len_i == {LEN_W{1'b0}})) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (start_i) begin
               state_d  = RUN;
               busy_d   = 1'b1;
               csn_d    = 1'b0;
               add_d    = base_i;
               remain_d = len_i - LEN_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (remain_q == {LEN_W{1'b0}}) begin
               state_d = DRAIN;
            end else if (can_issue_s) begin
               csn_d    = 1'b0;
               add_d    = add_q + WORD_STEP;
               remain_d = remain_q - LEN_W'(1);
               state_d  = (remain_q == LEN_W'(1)) ? DRAIN : RUN;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            if (csn_q && !rvalid_q && fifo_empty_s) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // FSM and ROM-port registers; reset also drops any read still returning.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         csn_q    <= 1'b1;
         add_q    <= 32'h0;
         remain_q <= {LEN_W{1'b0}};
         rvalid_q <= 1'b0;
         rtag_q   <= 32'h0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         csn_q    <= csn_d;
         add_q    <= add_d;
         remain_q <= remain_d;
         rvalid_q <= rvalid_d;
         rtag_q   <= rtag_d;
      end
   end

   assign push_entry_s.addr = rtag_q;
   assign push_entry_s.data = rom_rdata_i;

   boot_rom_reader_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (fifo_entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rvalid_q),
      .data_i  (push_entry_s),
      .pop_i   (pop_s),
      .data_o  (pop_entry_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

`ifdef BOOT_ROM_READER_CHECKSUM_EN
   logic [31:0] checksum_q;
   logic [31:0] checksum_d;
   logic        sum_clr_s;

   // Every accepted start, zero-length included, restarts the sum.
   always_comb begin
      sum_clr_s = (state_q == IDLE) && start_i && !req_bad_s;
      if (sum_clr_s) begin
         checksum_d = 32'h0;
      end else if (pop_s) begin
         checksum_d = checksum_q + pop_entry_s.data;
      end else begin
         checksum_d = checksum_q;
      end
   end

   // Checksum register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         checksum_q <= 32'h0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum_o = checksum_q;
`else
   assign checksum_o = 32'h0;
`endif

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign rom_csn_o   = csn_q;
   assign rom_add_o   = add_q;
   assign rom_wen_o   = 1'b1;
   assign rom_be_o    = 1'b1;
   assign rom_wdata_o = 32'h0;
   assign rom_id_o    = ID;
   assign m_valid_o   = !fifo_empty_s;
   assign m_data_o    = pop_entry_s.data;
   assign m_addr_o    = pop_entry_s.addr;

endmodule

// File: tb/tb_boot_rom_reader.sv
// Randomised self-checking bench for boot_rom_reader: a behavioural ROM, a queue of
// expected beats derived from the request, and protocol checks on both ports.
module tb_boot_rom_reader;

   localparam int          AW        = 13;
   localparam logic [31:0] OFFS      = 32'h1a00_0000;
   localparam longint      ROM_WORDS = 64'd8192;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] base_i;
   logic [AW:0] len_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        rom_csn_o;
   logic        rom_wen_o;
   logic        rom_be_o;
   logic [31:0] rom_add_o;
   logic [31:0] rom_wdata_o;
   logic [3:0]  rom_id_o;
   logic [31:0] rom_rdata_i;
   logic        m_valid_o;
   logic        m_ready_i;
   logic [31:0] m_data_o;
   logic [31:0] m_addr_o;
   logic [31:0] checksum_o;

   int          n_vec;
   int          n_err;
   logic [31:0] rom_salt;
   int          ready_mode;
   logic [0:3]  rdy_pat = 4'b1001;

   logic [63:0] exp_q[$];
   logic [31:0] issue_next;
   int          issued;
   int          popped;
   int          exp_len;
   bit          mon_en;
   bit          prev_stall;
   logic [31:0] prev_addr;
   logic [31:0] prev_data;

   boot_rom_reader dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .base_i      (base_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .rom_csn_o   (rom_csn_o),
      .rom_wen_o   (rom_wen_o),
      .rom_be_o    (rom_be_o),
      .rom_add_o   (rom_add_o),
      .rom_wdata_o (rom_wdata_o),
      .rom_id_o    (rom_id_o),
      .rom_rdata_i (rom_rdata_i),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .m_data_o    (m_data_o),
      .m_addr_o    (m_addr_o),
      .checksum_o  (checksum_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (32'h1000 + ((a - OFFS) >> 2)) ^ rom_salt;
   endfunction

   // ROM macro: data for an address appears one cycle after chip select.
   always @(posedge clk_i) begin
      if (!rom_csn_o) rom_rdata_i <= rom_word(rom_add_o);
      else            rom_rdata_i <= 32'hdead_beef;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Downstream ready: 0 = always, 1 = 1,0,0,1 pattern, otherwise random.
   initial begin
      int k;
      k = 0;
      m_ready_i = 1'b1;
      forever begin
         @(posedge clk_i);
         #1;
         case (ready_mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = rdy_pat[k % 4];
            default: m_ready_i = 1'($urandom_range(0, 1));
         endcase
         k++;
      end
   end

   // Port monitor: ROM issue order and back-pressure bound, beat order and stability.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk_i);
         if (mon_en) begin
            if (!rom_csn_o) begin
               check_eq("issue_addr", rom_add_o, issue_next);
               issue_next = issue_next + 32'd4;
               issued++;
               check_eq("issue_in_range", 32'(issued <= exp_len), 32'd1);
               check_eq("outstanding_le_4", 32'(issued - popped <= 4), 32'd1);
            end
            if (prev_stall) begin
               check_eq("stall_valid", 32'(m_valid_o), 32'd1);
               check_eq("stall_addr", m_addr_o, prev_addr);
               check_eq("stall_data", m_data_o, prev_data);
            end
            if (m_valid_o && m_ready_i) begin
               check_eq("beat_pending", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check_eq("beat_addr", m_addr_o, e[63:32]);
                  check_eq("beat_data", m_data_o, e[31:0]);
               end
               popped++;
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_addr  = m_addr_o;
            prev_data  = m_data_o;
         end
      end
   end

   task automatic check_reset(input string tag);
      check_eq({tag, "/busy"}, 32'(busy_o), 32'd0);
      check_eq({tag, "/done"}, 32'(done_o), 32'd0);
      check_eq({tag, "/err"}, 32'(err_o), 32'd0);
      check_eq({tag, "/csn"}, 32'(rom_csn_o), 32'd1);
      check_eq({tag, "/add"}, rom_add_o, 32'h0);
      check_eq({tag, "/m_valid"}, 32'(m_valid_o), 32'd0);
      check_eq({tag, "/m_data"}, m_data_o, 32'h0);
      check_eq({tag, "/m_addr"}, m_addr_o, 32'h0);
      check_eq({tag, "/checksum"}, checksum_o, 32'h0);
   endtask

   task automatic arm_model(input logic [31:0] base, input int len, input bit bad, output logic [31:0] sum);
      exp_q.delete();
      sum        = 32'h0;
      issue_next = base;
      issued     = 0;
      popped     = 0;
      exp_len    = bad ? 0 : len;
      prev_stall = 1'b0;
      if (!bad) begin
         for (int i = 0; i < len; i++) begin
            exp_q.push_back({base + 32'(4 * i), rom_word(base + 32'(4 * i))});
            sum = sum + rom_word(base + 32'(4 * i));
         end
      end
      mon_en = 1'b1;
   endtask

   task automatic run_xfer(input logic [31:0] base, input int len, input int mode, input string tag);
      logic [31:0] sum;
      bit          bad;
      int          cyc;
      bad = (base[1:0] != 2'b00) || (base < OFFS);
      if (!bad) bad = (longint'(base - OFFS) / 4 + longint'(len)) > ROM_WORDS;
      ready_mode = mode;
      arm_model(base, len, bad, sum);
      @(posedge clk_i);
      #1;
      base_i  = base;
      len_i   = (AW + 1)'(len);
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      base_i  = $urandom();
      len_i   = (AW + 1)'($urandom());
      @(negedge clk_i);
      if (bad) begin
         check_eq({tag, "/err_pulse"}, 32'(err_o), 32'd1);
         check_eq({tag, "/err_busy"}, 32'(busy_o), 32'd0);
         check_eq({tag, "/err_csn"}, 32'(rom_csn_o), 32'd1);
         @(negedge clk_i);
         check_eq({tag, "/err_one_cycle"}, 32'(err_o), 32'd0);
         repeat (4) @(negedge clk_i);
         check_eq({tag, "/err_no_reads"}, 32'(issued), 32'd0);
      end else if (len == 0) begin
         check_eq({tag, "/len0_done"}, 32'(done_o), 32'd1);
         check_eq({tag, "/len0_busy"}, 32'(busy_o), 32'd0);
         for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_eq({tag, "/len0_no_valid"}, 32'(m_valid_o), 32'd0);
            check_eq({tag, "/len0_done_once"}, 32'(done_o), 32'd0);
         end
         check_eq({tag, "/len0_no_reads"}, 32'(issued), 32'd0);
      end else begin
         check_eq({tag, "/busy"}, 32'(busy_o), 32'd1);
         check_eq({tag, "/done_early"}, 32'(done_o), 32'd0);
         cyc = 1;
         while (!m_valid_o && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
         end
         check_eq({tag, "/first_valid_lat"}, 32'(cyc), 32'd3);
         if (mode != 0) begin
            start_i = 1'b1;
            base_i  = OFFS + 32'h400;
            len_i   = (AW + 1)'(5);
            @(negedge clk_i);
            start_i = 1'b0;
         end
         cyc = 0;
         while (!done_o && cyc < 2000) begin
            @(negedge clk_i);
            cyc++;
         end
         check_eq({tag, "/done_seen"}, 32'(done_o), 32'd1);
         check_eq({tag, "/done_busy"}, 32'(busy_o), 32'd0);
         check_eq({tag, "/beats_left"}, 32'(exp_q.size()), 32'd0);
         check_eq({tag, "/reads"}, 32'(issued), 32'(len));
`ifdef BOOT_ROM_READER_CHECKSUM_EN
         check_eq({tag, "/checksum"}, checksum_o, sum);
`else
         check_eq({tag, "/checksum_off"}, checksum_o, 32'h0);
`endif
         @(negedge clk_i);
         check_eq({tag, "/done_once"}, 32'(done_o), 32'd0);
         check_eq({tag, "/idle_busy"}, 32'(busy_o), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] sum;
      logic [31:0] base;
      int          len;
      int          cyc;
      int          r;
      n_vec      = 0;
      n_err      = 0;
      mon_en     = 1'b0;
      prev_stall = 1'b0;
      ready_mode = 0;
      rom_salt   = 32'h0;
      exp_len    = 0;
      issued     = 0;
      popped     = 0;
      rst_i      = 1'b1;
      start_i    = 1'b0;
      base_i     = 32'h0;
      len_i      = '0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check_reset("reset");
      check_eq("wen_tied", 32'(rom_wen_o), 32'd1);
      check_eq("be_tied", 32'(rom_be_o), 32'd1);
      check_eq("wdata_tied", rom_wdata_o, 32'h0);
      check_eq("id", 32'(rom_id_o), 32'd0);

      run_xfer(OFFS, 4, 0, "basic");
`ifdef BOOT_ROM_READER_CHECKSUM_EN
      check_eq("basic/checksum_const", checksum_o, 32'h4006);
`endif
      run_xfer(OFFS, 4, 1, "stall");
      run_xfer(OFFS + 32'd2, 4, 0, "misaligned");
      run_xfer(32'h19ff_fffc, 4, 0, "below_base");
      run_xfer(32'h1a00_7ffc, 2, 0, "past_end");
      run_xfer(OFFS + 32'h20, 0, 0, "len0");

      ready_mode = 0;
      arm_model(OFFS + 32'h40, 8, 1'b0, sum);
      @(posedge clk_i);
      #1;
      base_i  = OFFS + 32'h40;
      len_i   = (AW + 1)'(8);
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      cyc = 0;
      while (popped < 2 && cyc < 50) begin
         @(negedge clk_i);
         cyc++;
      end
      check_eq("mid_rst/two_beats", 32'(popped >= 2), 32'd1);
      @(posedge clk_i);
      #1;
      rst_i  = 1'b1;
      mon_en = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check_reset("mid_rst");
      run_xfer(OFFS + 32'h100, 1, 0, "after_rst");

      run_xfer(32'h1a00_7ffc, 1, 0, "last_word");

      for (int it = 0; it < 16; it++) begin
         rom_salt = $urandom();
         r = int'($urandom_range(0, 5));
         if (r == 0) begin
            len  = int'($urandom_range(3, 12));
            base = OFFS + 32'(4 * $urandom_range(8190, 8191));
         end else if (r == 1) begin
            len  = int'($urandom_range(1, 8));
            base = OFFS + 32'(4 * $urandom_range(0, 100)) + 32'($urandom_range(1, 3));
         end else if (r == 2) begin
            len  = int'($urandom_range(1, 8));
            base = OFFS - 32'(4 * $urandom_range(1, 100));
         end else begin
            len  = int'($urandom_range(0, 12));
            base = OFFS + 32'(4 * $urandom_range(0, 8192 - len));
         end
         run_xfer(base, len, int'($urandom_range(0, 2)), $sformatf("rand%0d", it));
      end

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/boot_rom_reader.md
Name: boot_rom_reader

Overview:
- Initiator-side engine for the boot ROM memory port. Issues sequential word reads (csn/add/wen/be/id) and captures rdata.
- Buffers read data and streams it out on a valid/ready interface to the boot loader/copy path.
- Sits between the ROM macro and the SoC boot sequencer. Keeps a running checksum of delivered words.

Parameters:
- ROM_ADDR_WIDTH, 13, word-address width of the ROM (ROM size = 2^ROM_ADDR_WIDTH words).
- AddrOffset, 32'h1a000000, byte base address of the ROM in the SoC map.
- FIFO_DEPTH, 4, read-data buffer entries (power of two, >=2).
- ID, 4'h0, constant driven on rom_id_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- base_i  in  32  byte address of the first word.
- len_i  in  ROM_ADDR_WIDTH+1  number of words to read.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse on rejected request.
- rom_csn_o  out  1  chip select, active low.
- rom_wen_o  out  1  write enable, active low; tied 1 (read-only).
- rom_be_o  out  1  byte enable; tied 1.
- rom_add_o  out  32  byte address of the read.
- rom_wdata_o  out  32  tied 0.
- rom_id_o  out  4  = ID.
- rom_rdata_i  in  32  read data, valid one cycle after rom_csn_o low.
- m_valid_o  out  1  output beat valid.
- m_ready_i  in  1  downstream ready.
- m_data_o  out  32  word data.
- m_addr_o  out  32  byte address the word was read from.
- checksum_o  out  32  running checksum.

Behaviour:
- Reset values: busy_o=0, done_o=0, err_o=0, rom_csn_o=1, rom_add_o=0, m_valid_o=0, m_data_o=0, m_addr_o=0, checksum_o=0. Reset flushes the FIFO and discards in-flight rdata, at any point in a transfer.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, start_i=1, validity checks:
  - Error if base_i[1:0]!=0.
  - Error if base_i<AddrOffset.
  - Error if (base_i-AddrOffset)/4+len_i > 2^ROM_ADDR_WIDTH (computed 33-bit, no wrap).
  - On error: err_o pulses next cycle, state stays IDLE, no ROM access.
- IDLE, len_i=0 (and checks pass): go to DONE. done_o pulses next cycle, no reads.
- IDLE, valid request: latch base and len, clear checksum_o, go to RUN. busy_o=1 from the next cycle.
- RUN:
  - A read issues (rom_csn_o=0, rom_add_o=base+4*i) when fifo_count+inflight < FIFO_DEPTH. inflight is 0 or 1.
  - rdata is pushed, tagged with its address, in the cycle after issue.
  - After the last issue, go to DRAIN.
- DRAIN: wait until inflight=0 and the FIFO is empty with the last beat handshaken, then go to DONE.
- DONE: done_o=1 and busy_o=0 for one cycle, then IDLE.
- start_i while busy_o=1 is ignored.
- Output handshake:
  - A beat transfers when m_valid_o & m_ready_i.
  - m_data_o/m_addr_o hold stable while m_valid_o=1 and m_ready_i=0.
  - FIFO output is registered. First m_valid_o is 3 cycles after the start_i cycle.
  - Throughput is 1 word/cycle with m_ready_i held high.
- Simultaneous push and pop on a full FIFO is legal; count unchanged.
- rom_add_o holds its last value while rom_csn_o=1.
- Checksum: checksum_o += m_data_o on each handshake, mod 2^32.

Optional Feature:
- BOOT_ROM_READER_CHECKSUM_EN defined: checksum_o is the running sum above, cleared on accepted start.
- Not defined: checksum_o tied to 32'h0 and the adder is removed.

Decomposition:
- Package boot_rom_reader_pkg: state enum (IDLE/RUN/DRAIN/DONE), default AddrOffset, word-size constant (4), FIFO entry struct {addr[31:0], data[31:0]}.
- Sub-module boot_rom_reader_fifo: synchronous FIFO, push/pop/full/empty/count, registered output, parameterised on depth and entry type.

Test Plan:
- base=32'h1a000000, len=4, m_ready_i=1, ROM word k = 32'h1000+k → reads at 0x1a000000..0x1a00000c on consecutive cycles; 4 beats with correct addr/data; checksum_o=32'h4006; done_o pulses once.
- Same transfer with m_ready_i toggling 1,0,0,1 → no beat lost or duplicated; data stable during stall; issue stops when FIFO + inflight reaches 4.
- base=32'h1a000002 → err_o pulse, rom_csn_o stays 1. base=32'h19fffffc → err_o. base=32'h1a007ffc, len=2 → err_o (exceeds 8192 words).
- len=0 → done_o pulses one cycle later; no ROM access; m_valid_o never asserted.
- rst_i asserted after 2 of 8 words delivered → all outputs at reset values next cycle; a new start with len=1 completes cleanly.
- Boundary: base=32'h1a007ffc, len=1 → single read at last ROM word; done_o pulses.
